// File: rtl/avalon_pio_pkg.sv
// Shared register map and helpers for the edge-capturing PIO slave.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_RISE = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_CAP  = 3'd3;
  localparam logic [2:0] ADDR_FALL = 3'd4;

  // A bypassed filter (0 cycles) still gets a 1-bit counter so widths never collapse to zero.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pio_sync_debounce.sv
// One input bit: SYNC_STAGES-flop synchroniser followed by a stable-count debounce filter.
module pio_sync_debounce
  import avalon_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic filt
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_chain <= '0;
    else          sync_chain <= {sync_chain[SYNC_STAGES-2:0], in_bit};
  end

  assign sync = sync_chain[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign filt = sync;
    end else begin : g_filter
      localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          filt_q;

      // Counter only runs while sync disagrees with filt; any return to agreement restarts it.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt    <= '0;
          filt_q <= 1'b0;
        end else if (sync == filt_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          filt_q <= sync;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign filt = filt_q;
    end
  endgenerate

endmodule

// File: rtl/avalon_pio_edge_irq.sv
// Avalon-MM PIO slave: per-bit sync/debounce, programmable rise/fall edge capture (W1C), masked level irq.
module avalon_pio_edge_irq
  import avalon_pio_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RISE_EN_RST     = '0,
  parameter logic [WIDTH-1:0] FALL_EN_RST     = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_mux;
  logic             wr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pio_sync_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .in_bit (in_port[i]),
      .filt   (filt[i])
    );
  end

  assign wr           = chipselect && !write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign det          = (filt & ~filt_d & rise_en) | (~filt & filt_d & fall_en);
  assign clr          = (wr && address == ADDR_CAP) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_d       <= '0;
      rise_en      <= RISE_EN_RST;
      fall_en      <= FALL_EN_RST;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      filt_d <= filt;
      // OR-ing det last lets a fresh edge win over a same-cycle clear.
      edge_capture <= (edge_capture & ~clr) | det;
      if (wr && address == ADDR_RISE) rise_en  <= wdata;
      if (wr && address == ADDR_MASK) irq_mask <= wdata;
      if (wr && address == ADDR_FALL) fall_en  <= wdata;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = filt;
      ADDR_RISE: rd_mux = rise_en;
      ADDR_MASK: rd_mux = irq_mask;
      ADDR_CAP:  rd_mux = edge_capture;
      ADDR_FALL: rd_mux = fall_en;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= 32'(rd_mux);
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_avalon_pio_edge_irq.sv
// Directed bench for avalon_pio_edge_irq with default parameters (WIDTH=8, 2 sync stages, 4-cycle debounce).
module tb_avalon_pio_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  avalon_pio_edge_irq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    chipselect = 1'b0;
    d          = readdata;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    reg_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic check_reset_values(input string tag);
    logic [31:0] exp_tab [8];
    exp_tab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFF, 32'h0, 32'h0, 32'h0};
    for (int a = 0; a < 8; a++) read_check($sformatf("%s_addr%0d", tag, a), 3'(a), exp_tab[a]);
    check({tag, "_irq"}, {31'h0, irq}, 32'h0);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 8'h00;

    // Reset values
    ticks(3);
    check("in_reset_readdata", readdata, 32'h0);
    check("in_reset_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    tick();
    check_reset_values("reset");

    // Default falling-edge behaviour, exact latency 2+4 edges
    in_port = 8'h01;
    ticks(10);
    read_check("rise_data", 3'd0, 32'h01);
    read_check("rise_not_captured", 3'd3, 32'h00);
    reg_write(3'd2, 32'h01);
    in_port = 8'h00;
    ticks(6);
    check("fall_irq_early", {31'h0, irq}, 32'h0);
    tick();
    check("fall_irq_exact", {31'h0, irq}, 32'h1);
    read_check("fall_cap", 3'd3, 32'h01);
    reg_write(3'd2, 32'h00);
    check("mask_gates_irq", {31'h0, irq}, 32'h0);
    reg_write(3'd2, 32'h01);
    check("mask_ungates_irq", {31'h0, irq}, 32'h1);
    reg_write(3'd3, 32'h01);
    check("w1c_irq", {31'h0, irq}, 32'h0);
    read_check("w1c_cap", 3'd3, 32'h00);

    // Both-edge mode on bit 7
    reg_write(3'd1, 32'h80);
    reg_write(3'd4, 32'h80);
    reg_write(3'd2, 32'h80);
    read_check("rise_en_rb", 3'd1, 32'h80);
    read_check("fall_en_rb", 3'd4, 32'h80);
    in_port = 8'h80;
    ticks(10);
    check("b7_rise_irq", {31'h0, irq}, 32'h1);
    read_check("b7_rise_cap", 3'd3, 32'h80);
    reg_write(3'd1, 32'h00);
    read_check("rise_dis_keeps_cap", 3'd3, 32'h80);
    reg_write(3'd3, 32'h80);
    read_check("b7_clr", 3'd3, 32'h00);
    in_port = 8'h00;
    ticks(10);
    check("b7_fall_irq", {31'h0, irq}, 32'h1);
    read_check("b7_fall_cap", 3'd3, 32'h80);
    reg_write(3'd3, 32'h80);
    read_check("b7_data", 3'd0, 32'h00);

    // Glitch rejection on bit 3
    reg_write(3'd1, 32'h08);
    reg_write(3'd2, 32'h08);
    in_port = 8'h08;
    ticks(3);
    in_port = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dut.filt !== 8'h00) check("glitch_filt", {24'h0, dut.filt}, 32'h0);
    end
    read_check("glitch_data", 3'd0, 32'h00);
    read_check("glitch_cap", 3'd3, 32'h00);
    check("glitch_irq", {31'h0, irq}, 32'h0);
    in_port = 8'h08;
    ticks(4);
    in_port = 8'h00;
    ticks(15);
    read_check("pulse4_cap", 3'd3, 32'h08);
    check("pulse4_irq", {31'h0, irq}, 32'h1);
    reg_write(3'd3, 32'h08);
    check("pulse4_clr_irq", {31'h0, irq}, 32'h0);

    // Simultaneous set and clear on bit 1: set wins
    reg_write(3'd1, 32'h02);
    in_port = 8'h02;
    ticks(6);
    reg_write(3'd3, 32'h02);
    read_check("set_wins", 3'd3, 32'h02);
    reg_write(3'd3, 32'h02);
    read_check("later_clear", 3'd3, 32'h00);

    // Reset in the middle of a debounce
    in_port = 8'h00;
    ticks(12);
    reg_write(3'd1, 32'h01);
    reg_write(3'd2, 32'h01);
    in_port = 8'h01;
    ticks(4);
    reset_n = 1'b0;
    in_port = 8'h00;
    ticks(2);
    check("mid_reset_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    tick();
    check_reset_values("mid_reset");
    ticks(10);
    read_check("mid_reset_no_cap", 3'd3, 32'h00);
    read_check("mid_reset_data", 3'd0, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
